ifetch_ctrl: RTL and testbench



---
 rtl/ifetch_pkg.sv | 28 ++
 rtl/ifetch_buf.sv | 106 ++++++++++
 rtl/ifetch_ctrl.sv | 115 +++++++++++
 tb/tb_ifetch_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared types and constants for the instruction-fetch
//                controller (ROM geometry, controller state, queue entry).
//  Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam int IMEM_DEPTH = 128;
    localparam int IMEM_AW    = 7;

    // Default PC / instruction widths used by the packed entry type
    localparam int IFETCH_N   = 64;
    localparam int IFETCH_W   = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } ifetch_state_t;

    typedef struct packed {
        logic [IFETCH_N-1:0] pc;
        logic [IFETCH_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_buf
//  Description : Two-entry registered FIFO holding fetched {pc, instr} pairs.
//                Flush wins over push and pop. Slot 0 is always the head, so
//                the head outputs come straight from flops and keep their
//                last value once the queue empties.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int N = 64,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [N-1:0] push_pc,
    input  logic [W-1:0] push_instr,
    output logic [1:0]   count,
    output logic         head_valid,
    output logic [N-1:0] head_pc,
    output logic [W-1:0] head_instr
);

    logic [1:0]   cnt_q,     cnt_d;
    logic [N-1:0] s0_pc_q,   s0_pc_d;
    logic [W-1:0] s0_ins_q,  s0_ins_d;
    logic [N-1:0] s1_pc_q,   s1_pc_d;
    logic [W-1:0] s1_ins_q,  s1_ins_d;
    logic         w_pop;

    // A pop on an empty queue is meaningless; ignore it
    assign w_pop = pop & (cnt_q != 2'd0);

    // Next-state of occupancy and slots; slot 1 shifts into slot 0 on pop
    always_comb begin
        cnt_d    = cnt_q;
        s0_pc_d  = s0_pc_q;
        s0_ins_d = s0_ins_q;
        s1_pc_d  = s1_pc_q;
        s1_ins_d = s1_ins_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, w_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        s0_pc_d  = push_pc;
                        s0_ins_d = push_instr;
                    end else begin
                        s1_pc_d  = push_pc;
                        s1_ins_d = push_instr;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    if (cnt_q == 2'd2) begin
                        s0_pc_d  = s1_pc_q;
                        s0_ins_d = s1_ins_q;
                    end
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        s0_pc_d  = s1_pc_q;
                        s0_ins_d = s1_ins_q;
                        s1_pc_d  = push_pc;
                        s1_ins_d = push_instr;
                    end else begin
                        s0_pc_d  = push_pc;
                        s0_ins_d = push_instr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Queue registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= 2'd0;
            s0_pc_q  <= '0;
            s0_ins_q <= '0;
            s1_pc_q  <= '0;
            s1_ins_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            s0_pc_q  <= s0_pc_d;
            s0_ins_q <= s0_ins_d;
            s1_pc_q  <= s1_pc_d;
            s1_ins_q <= s1_ins_d;
        end
    end

    assign count      = cnt_q;
    assign head_valid = (cnt_q != 2'd0);
    assign head_pc    = s0_pc_q;
    assign head_instr = s0_ins_q;

endmodule
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_ctrl
//  Description : Instruction-fetch controller. Owns the fetch PC, addresses
//                the combinational instruction ROM, queues fetched words in a
//                2-entry buffer and applies branch redirects with a flush.
//                Optional macro IFETCH_BOUND_CHECK_EN enables the FAULT state
//                for fetches outside the ROM or misaligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int N = 64,
    parameter int W = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [W-1:0]       imem_q,
    output logic               instr_valid,
    output logic [W-1:0]       instr,
    output logic [N-1:0]       instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [N-1:0]       redirect_pc,
    output logic               fetch_fault
);

    logic [N-1:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]   w_count;
    logic         w_pop;
    logic         w_room;
    logic         w_push;

    assign w_pop     = instr_valid & instr_ready;
    // A full queue can still accept a word when the head leaves this cycle
    assign w_room    = (w_count != 2'd2) | w_pop;
    assign imem_addr = fetch_pc_q[IMEM_AW+1:2];

`ifdef IFETCH_BOUND_CHECK_EN
    ifetch_state_t state_q, state_d;
    logic          w_fetch_try;
    logic          w_illegal;

    assign w_illegal   = (|fetch_pc_q[N-1:IMEM_AW+2]) | (|fetch_pc_q[1:0]);
    assign w_fetch_try = (state_q == RUN) & ~redirect & w_room;
    assign w_push      = w_fetch_try & ~w_illegal;
    assign fetch_fault = (state_q == FAULT);

    // Enter FAULT on an illegal fetch attempt; only a redirect leaves it
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = RUN;
        end else if (w_fetch_try & w_illegal) begin
            state_d = FAULT;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end
`else
    // Out-of-range and misaligned PCs simply alias into the ROM
    logic w_unused_pc;

    assign w_unused_pc = ^{fetch_pc_q[N-1:IMEM_AW+2], fetch_pc_q[1:0]};
    assign w_push      = ~redirect & w_room;
    assign fetch_fault = 1'b0;
`endif

    // Redirect overrides sequential advance; PC wraps modulo 2^N
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (w_push) begin
            fetch_pc_d = fetch_pc_q + N'(4);
        end
    end

    // Fetch PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    ifetch_buf #(
        .N (N),
        .W (W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .pop        (w_pop),
        .flush      (redirect),
        .push_pc    (fetch_pc_q),
        .push_instr (imem_q),
        .count      (w_count),
        .head_valid (instr_valid),
        .head_pc    (instr_pc),
        .head_instr (instr)
    );

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_ctrl
//  Description : Self-checking bench for ifetch_ctrl with a stub ROM and a
//                queue-based reference model, plus literal spot checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  imem_addr;
    logic [31:0] imem_q;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_q = 32'hA000_0000 | {25'd0, imem_addr};

    ifetch_ctrl #(.N(64), .W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_fault (fetch_fault)
    );

    // Reference model state
    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_fpc      = '0;
    bit          m_fault    = 1'b0;
    logic [63:0] m_last_pc  = '0;
    logic [31:0] m_last_ins = '0;

    function automatic logic [31:0] rom(input logic [63:0] pc);
        return 32'hA000_0000 | {25'd0, pc[8:2]};
    endfunction

    function automatic bit illegal(input logic [63:0] pc);
`ifdef IFETCH_BOUND_CHECK_EN
        return (pc[63:9] != 55'd0) || (pc[1:0] != 2'd0);
`else
        return 1'b0 & pc[0];
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        ent_t e;
        bit   pop;
        if (reset) begin
            mq.delete();
            m_fpc      = '0;
            m_fault    = 1'b0;
            m_last_pc  = '0;
            m_last_ins = '0;
            return;
        end
        pop = (mq.size() > 0) && instr_ready;
        if (redirect) begin
            mq.delete();
            m_fpc   = redirect_pc;
            m_fault = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_fault && mq.size() < 2) begin
                if (illegal(m_fpc)) begin
                    m_fault = 1'b1;
                end else begin
                    e.pc  = m_fpc;
                    e.ins = rom(m_fpc);
                    mq.push_back(e);
                    m_fpc = m_fpc + 64'd4;
                end
            end
        end
        if (mq.size() > 0) begin
            m_last_pc  = mq[0].pc;
            m_last_ins = mq[0].ins;
        end
    endtask

    // One clock: update model, take the edge, compare all outputs
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("instr_valid", {63'd0, instr_valid}, {63'd0, mq.size() > 0});
        chk("instr",       {32'd0, instr},       {32'd0, m_last_ins});
        chk("instr_pc",    instr_pc,             m_last_pc);
        chk("imem_addr",   {57'd0, imem_addr},   {57'd0, m_fpc[8:2]});
        chk("fetch_fault", {63'd0, fetch_fault}, {63'd0, m_fault});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        instr_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_pc",    instr_pc, 64'd0);
        chk("rst_fault", {63'd0, fetch_fault}, 64'd0);

        // Streaming with decode always ready
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_pc",    instr_pc, 64'(4 * i));
            chk("stream_instr", {32'd0, instr}, {32'd0, 32'hA000_0000 + 32'(i)});
        end

        // Decode stall: queue saturates, ROM address freezes
        do_reset();
        instr_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        chk("stall_addr", {57'd0, imem_addr}, 64'd2);
        chk("stall_pc",   instr_pc, 64'd0);
        instr_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("release_pc", instr_pc, 64'(4 * i));
        end

        // Redirect while full and stalled
        instr_ready = 1'b0;
        step();
        step();
        redirect = 1'b1;
        redirect_pc = 64'h40;
        step();
        chk("redir_full_valid", {63'd0, instr_valid}, 64'd0);
        redirect = 1'b0;
        step();
        chk("redir_full_pc",    instr_pc, 64'h40);
        chk("redir_full_instr", {32'd0, instr}, 64'hA000_0010);

        // Redirect coinciding with a pop
        instr_ready = 1'b1;
        step();
        step();
        redirect = 1'b1;
        redirect_pc = 64'h100;
        step();
        chk("redir_pop_valid", {63'd0, instr_valid}, 64'd0);
        redirect = 1'b0;
        step();
        chk("redir_pop_pc",    instr_pc, 64'h100);
        chk("redir_pop_instr", {32'd0, instr}, 64'hA000_0040);
        step();

`ifdef IFETCH_BOUND_CHECK_EN
        // Out-of-range target faults, then recovers on a legal redirect
        redirect = 1'b1;
        redirect_pc = 64'h200;
        step();
        redirect = 1'b0;
        step();
        chk("fault_set",   {63'd0, fetch_fault}, 64'd1);
        chk("fault_valid", {63'd0, instr_valid}, 64'd0);
        step();
        redirect = 1'b1;
        redirect_pc = 64'h8;
        step();
        chk("fault_clr", {63'd0, fetch_fault}, 64'd0);
        redirect = 1'b0;
        step();
        chk("fault_rec_pc", instr_pc, 64'h8);
`else
        // Out-of-range target aliases into the ROM
        redirect = 1'b1;
        redirect_pc = 64'h204;
        step();
        redirect = 1'b0;
        step();
        chk("alias_instr", {32'd0, instr}, 64'hA000_0001);
        chk("alias_fault", {63'd0, fetch_fault}, 64'd0);
        // PC wrap at the top of the address space
        redirect = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        chk("wrap_instr", {32'd0, instr}, 64'hA000_007F);
        step();
        chk("wrap_pc", instr_pc, 64'd0);
`endif

        // Irregular decode back-pressure
        redirect = 1'b1;
        redirect_pc = 64'h20;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 24; i++) begin
            instr_ready = (((i * 7) % 5) < 2);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
